mod_pipe_elastic_reg: RTL

//   Parametrised elastic pipeline register; the generalised successor to the fixed-field stall/reset stage registers.

---
 rtl/mod_pipe_elastic_reg.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mod_pipe_elastic_reg.sv
// Elastic valid/ready pipeline register with a 2-entry skid buffer, flush,
// bubble control zeroing and a saturating back-pressure counter.
module mod_pipe_elastic_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              cnt_clr_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CTRL_W-1:0]  head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0]  head_data_q, head_data_d;
  logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               in_fire;
  logic               out_fire;

  // Handshake outputs decode only flopped state, so ready_i never reaches ready_o.
  assign valid_o     = (state_q != EMPTY);
  assign ready_o     = (state_q != FULL);
  assign ctrl_o      = head_ctrl_q;
  assign data_o      = head_data_q;
  assign stall_cnt_o = stall_cnt_q;
  assign in_fire     = valid_i & ready_o;
  assign out_fire    = valid_o & ready_i;

  always_comb begin
    occupancy_o = 2'd0;
    case (state_q)
      ONE:     occupancy_o = 2'd1;
      FULL:    occupancy_o = 2'd2;
      default: occupancy_o = 2'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    head_ctrl_d = head_ctrl_q;
    head_data_d = head_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      state_d     = EMPTY;
      head_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = ONE;
            head_ctrl_d = ctrl_i;
            head_data_d = data_i;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            head_ctrl_d = ctrl_i;
            head_data_d = data_i;
          end else if (in_fire) begin
            state_d     = FULL;
            skid_ctrl_d = ctrl_i;
            skid_data_d = data_i;
          end else if (out_fire) begin
            // Bubble: control must not leak, data is left as-is.
            state_d     = EMPTY;
            head_ctrl_d = '0;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d     = ONE;
            head_ctrl_d = skid_ctrl_q;
            head_data_d = skid_data_q;
          end
        end
        default: begin
          state_d     = EMPTY;
          head_ctrl_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr_i) begin
      stall_cnt_d = '0;
    end else if (valid_o && !ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= EMPTY;
      head_ctrl_q <= '0;
      head_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      head_ctrl_q <= head_ctrl_d;
      head_data_q <= head_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
